param_multi_bank_memory: RTL
============================

PARAM_MULTI_BANK_MEMORY -- requirements
Module: param_multi_bank_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning address width in bits.
REQ-003 The block SHALL have parameter BANK_BITS, default 2, meaning number of address MSBs used as the bank index (2**BANK_BITS banks).
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port ren  input  1  read request.
REQ-007 The block SHALL have port wen  input  1  write request.
REQ-008 The block SHALL have port waddr  input  ADDR_W  write address.
REQ-009 The block SHALL have port raddr  input  ADDR_W  read address.
REQ-010 The block SHALL have port din  input  DATA_W  write data.
REQ-011 The block SHALL have port dout  output  DATA_W  registered read data.
REQ-012 The block SHALL have port rvalid  output  1  dout valid, one cycle after ren.
REQ-013 The block SHALL have port wready  output  1  write accepted this cycle when high.
REQ-014 The block SHALL have port conflict  output  1  one-cycle pulse: write deferred by a bank conflict.

Function
REQ-015 Bank index SHALL be addr[ADDR_W-1 -: BANK_BITS]; row SHALL be the remaining low ADDR_W-BANK_BITS bits.
REQ-016 A write SHALL be accepted only when wen=1 and wready=1; wen while wready=0 is ignored (no state change).
REQ-017 wready SHALL equal !pend_valid, where pend_valid marks a one-entry pending-write buffer (addr, data).
REQ-018 Read latency SHALL be 1: on ren=1, dout and rvalid=1 appear on the next edge; on ren=0, dout<=0 and rvalid<=0.
REQ-019 An accepted write to a bank other than the bank being read, or with ren=0, SHALL commit to memory on the same edge.
REQ-020 An accepted write to the same bank as an active read SHALL NOT commit; it SHALL load the pending buffer, and conflict SHALL be 1 on the next cycle only.
REQ-021 The pending buffer SHALL drain (commit, pend_valid<=0) on the first edge where ren=0 or bank(raddr) differs from the pending bank.
REQ-022 A read of raddr equal to the pending address while pend_valid=1 SHALL return the pending data (forwarding).
REQ-023 A same-cycle read and write to the same address SHALL return the old memory contents (read-before-write).
REQ-024 Memory array contents SHALL NOT be reset; reading an unwritten location returns undefined data.

Reset
REQ-025 On rst=1 at a clock edge: dout=0, rvalid=0, conflict=0, pend_valid=0 (wready=1).
REQ-026 Reset mid-operation SHALL discard a pending write; committed memory contents SHALL be preserved.
REQ-027 While rst=1, ren and wen SHALL be ignored.

Structure
REQ-028 Default DATA_W/ADDR_W/BANK_BITS values and the bank/row slice widths SHALL live in shared package mbm_pkg.
REQ-029 One sub-module mbm_bank (one write port, one registered read port, 2**(ADDR_W-BANK_BITS) rows) SHALL be instantiated 2**BANK_BITS times via generate.
REQ-030 Pending buffer, conflict detection, forwarding mux, and output registers SHALL reside in the top level.

Verification
REQ-031 Write 0x057<=0x57, next cycle ren raddr=0x057 -> next cycle dout=0x57, rvalid=1, conflict=0.
REQ-032 Same cycle: ren raddr=0x28F, wen waddr=0x299 din=0x64 (both bank 1) -> next cycle conflict=1, wready=0; after ren=0 for one edge wready=1; later read 0x299 -> 0x64.
REQ-033 Pending 0x299/0x64 held by continuous ren raddr=0x299 -> dout=0x64 each cycle, wready=0 until ren drops.
REQ-034 Same cycle: wen waddr=0x57F din=0x4D (bank 2), ren raddr=0x77F (bank 3) -> conflict=0, wready stays 1; later read 0x57F -> 0x4D.
REQ-035 Create pending 0x299/0x11 over committed 0x64, assert rst one cycle -> dout=0, rvalid=0, wready=1; read 0x299 -> 0x64.
REQ-036 wen waddr=0x100 din=0xAA while wready=0, then read 0x100 -> the value written before the ignored write, unchanged.

Source files
------------

// File: rtl/mbm_pkg.sv
// Shared defaults for the banked memory: word/address widths and the bank/row split.
package mbm_pkg;
  localparam int MBM_DATA_W    = 8;
  localparam int MBM_ADDR_W    = 11;
  localparam int MBM_BANK_BITS = 2;
  localparam int MBM_ROW_W     = MBM_ADDR_W - MBM_BANK_BITS;
  localparam int MBM_NBANK     = 1 << MBM_BANK_BITS;
endpackage

// File: rtl/mbm_bank.sv
// One memory bank: single write port, single registered read port.
// Contents are never reset, and a same-edge read of a row being written returns the old word.
module mbm_bank #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_W-1:0]  wrow,
  input  logic [DATA_W-1:0] wdat,
  input  logic              re,
  input  logic [ROW_W-1:0]  rrow,
  output logic [DATA_W-1:0] rdat
);
  logic [DATA_W-1:0] mem [1 << ROW_W];

  always_ff @(posedge clk) begin
    if (we) mem[wrow] <= wdat;
    if (re) rdat <= mem[rrow];
  end
endmodule

// File: rtl/param_multi_bank_memory.sv
// Banked RAM with 1-cycle reads. A write that hits the bank being read is parked in a
// one-entry pending buffer (wready low) and drains on the first edge that bank is free.
module param_multi_bank_memory
  import mbm_pkg::*;
#(
  parameter int DATA_W    = MBM_DATA_W,
  parameter int ADDR_W    = MBM_ADDR_W,
  parameter int BANK_BITS = MBM_BANK_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              wready,
  output logic              conflict
);
  localparam int ROW_W = ADDR_W - BANK_BITS;
  localparam int NBANK = 1 << BANK_BITS;

  logic                 pend_valid;
  logic [ADDR_W-1:0]    pend_addr;
  logic [DATA_W-1:0]    pend_data;
  logic                 fwd_sel;
  logic [DATA_W-1:0]    fwd_data;
  logic [BANK_BITS-1:0] rd_bank_q;

  logic                 rd_en, wr_acc, wr_clash, drain;
  logic [BANK_BITS-1:0] rbank, wbank, pbank;
  logic [NBANK-1:0]     bank_we, bank_re;
  logic [ROW_W-1:0]     bank_wrow;
  logic [DATA_W-1:0]    bank_wdat;
  logic [DATA_W-1:0]    bank_rdat [NBANK];

  assign rbank = raddr[ADDR_W-1 -: BANK_BITS];
  assign wbank = waddr[ADDR_W-1 -: BANK_BITS];
  assign pbank = pend_addr[ADDR_W-1 -: BANK_BITS];

  assign wready   = !pend_valid;
  assign rd_en    = ren && !rst;
  assign wr_acc   = wen && wready && !rst;
  assign wr_clash = wr_acc && rd_en && (wbank == rbank);
  // New writes are only accepted with the buffer empty, so drain and a direct commit never collide.
  assign drain    = pend_valid && !rst && (!rd_en || (rbank != pbank));

  always_comb begin
    bank_we   = '0;
    bank_re   = '0;
    bank_wrow = waddr[ROW_W-1:0];
    bank_wdat = din;
    if (drain) begin
      bank_we[pbank] = 1'b1;
      bank_wrow      = pend_addr[ROW_W-1:0];
      bank_wdat      = pend_data;
    end else if (wr_acc && !wr_clash) begin
      bank_we[wbank] = 1'b1;
    end
    if (rd_en) bank_re[rbank] = 1'b1;
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    mbm_bank #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we[g]),
      .wrow (bank_wrow),
      .wdat (bank_wdat),
      .re   (bank_re[g]),
      .rrow (raddr[ROW_W-1:0]),
      .rdat (bank_rdat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      conflict   <= 1'b0;
      rvalid     <= 1'b0;
      fwd_sel    <= 1'b0;
    end else begin
      rvalid   <= rd_en;
      conflict <= wr_clash;
      fwd_sel  <= rd_en && pend_valid && (raddr == pend_addr);
      if (wr_clash)   pend_valid <= 1'b1;
      else if (drain) pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_clash) begin
      pend_addr <= waddr;
      pend_data <= din;
    end
    if (rd_en) begin
      rd_bank_q <= rbank;
      fwd_data  <= pend_data;
    end
  end

  // Output stage: a zero word whenever no read completed on the previous edge.
  assign dout = !rvalid ? '0 : (fwd_sel ? fwd_data : bank_rdat[rd_bank_q]);
endmodule
